// File: rtl/oka_pkg.sv
// Shared definitions for the iterative overlap-free Karatsuba carry-less
// multiplier.
//   oka_state_t : FSM state encoding (3 bits)
//   prod_w()    : product width helper, 2*W-1 for a W-bit operand pair
package oka_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL0 = 3'd1,
        MUL1 = 3'd2,
        MUL2 = 3'd3,
        DONE = 3'd4
    } oka_state_t;

    function automatic int prod_w(input int w);
        return 2 * w - 1;
    endfunction

endpackage

// File: rtl/oka_half_clmul.sv
// Purely combinational H x H carry-less (GF(2)[x]) multiplier.
// Schoolbook AND/XOR array; this is the single multiplier that the
// sequencer time-shares across the three Karatsuba partial products.
// Ports:
//   a, b : H-bit operands, bit i = coefficient of x^i
//   y    : (2H-1)-bit carry-less product
module oka_half_clmul #(
    parameter int H = 8
) (
    input  logic [H-1:0]   a,
    input  logic [H-1:0]   b,
    output logic [2*H-2:0] y
);

    always_comb begin
        y = '0;
        for (int i = 0; i < H; i++) begin
            for (int j = 0; j < H; j++) begin
                y[i+j] = y[i+j] ^ (a[i] & b[j]);
            end
        end
    end

endmodule

// File: rtl/oka_seq_ctrl.sv
// Iterative overlap-free Karatsuba carry-less multiplier.
// One shared H x H multiplier computes z0 (low halves), z2 (high halves)
// and the middle product m (half-sums) over three cycles; the product is
// assembled with XOR on the third compute cycle and held until taken.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready, a, b    : operand handshake (W-bit operands)
//   out_valid/out_ready, y     : product handshake ((2W-1)-bit product)
//   busy                 : high whenever the FSM is not in IDLE
module oka_seq_ctrl
    import oka_pkg::*;
#(
    parameter int W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          a,
    input  logic [W-1:0]          b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [prod_w(W)-1:0]  y,
    output logic                  busy
);

    localparam int H  = W / 2;
    localparam int PW = prod_w(W);
    localparam int HW = 2 * H - 1;   // half-product width

    oka_state_t     state, state_nxt;
    logic [W-1:0]   ra, rb;
    logic [HW-1:0]  z0, z2;
    logic [H-1:0]   ma, mb;
    logic [HW-1:0]  m;
    logic [HW-1:0]  mid;
    logic [PW-1:0]  y_comb;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid && in_ready) state_nxt = MUL0;
            MUL0:    state_nxt = MUL1;
            MUL1:    state_nxt = MUL2;
            MUL2:    state_nxt = DONE;
            DONE:    if (out_valid && out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- outputs / multiplier operand mux ----------------
    // The mux parks at zero outside the compute states so the shared
    // multiplier array does not toggle while idle or holding a result.
    always_comb begin
        in_ready = (state == IDLE) && !rst;
        busy     = (state != IDLE);
        ma       = '0;
        mb       = '0;
        case (state)
            MUL0: begin
                ma = ra[H-1:0];
                mb = rb[H-1:0];
            end
            MUL1: begin
                ma = ra[W-1:H];
                mb = rb[W-1:H];
            end
            MUL2: begin
                ma = ra[H-1:0] ^ ra[W-1:H];
                mb = rb[H-1:0] ^ rb[W-1:H];
            end
            default: ;
        endcase
    end

    oka_half_clmul #(.H(H)) u_mul (
        .a (ma),
        .b (mb),
        .y (m)
    );

    // Middle term z1 = m ^ z0 ^ z2 sits at x^H, z2 at x^W; the regions
    // overlap with z0/z2 and are merged by XOR (no carries in GF(2)).
    assign mid    = m ^ z0 ^ z2;
    assign y_comb = {{(PW-HW){1'b0}}, z0}
                  ^ ({{(PW-HW){1'b0}}, mid} << H)
                  ^ ({{(PW-HW){1'b0}}, z2}  << W);

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ra        <= '0;
            rb        <= '0;
            z0        <= '0;
            z2        <= '0;
            y         <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid && in_ready) begin
                    ra <= a;
                    rb <= b;
                end
                MUL0: z0 <= m;
                MUL1: z2 <= m;
                MUL2: begin
                    y         <= y_comb;
                    out_valid <= 1'b1;
                end
                DONE: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_oka_seq_ctrl.sv
module tb_oka_seq_ctrl;

    localparam int W  = 16;
    localparam int PW = 2 * W - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a, b;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] y;
    logic          busy;

    int ncmp = 0;
    int nbad = 0;
    logic [PW-1:0] sb_q[$];

    oka_seq_ctrl #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: plain 16x16 schoolbook carry-less multiply.
    function automatic logic [PW-1:0] clmul(input logic [W-1:0] x, input logic [W-1:0] z);
        logic [PW-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++)
            if (z[i]) r = r ^ ({{(PW-W){1'b0}}, x} << i);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ncmp++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with inputs already driven: records the
    // handshakes that the next rising edge will perform, then advances
    // to the following negedge.
    task automatic cyc();
        if (rst) begin
            sb_q.delete();
        end else begin
            if (in_valid && in_ready) sb_q.push_back(clmul(a, b));
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) chk("spurious_out", 64'(y), 64'hDEAD);
                else chk("y", 64'(y), 64'(sb_q.pop_front()));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // One operation with a free consumer; checks latency and in_ready gaps.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [PW-1:0] exp);
        int n;
        int guard;
        guard = 0;
        out_ready = 1'b1;
        while (!in_ready && guard < 50) begin cyc(); guard++; end
        chk("accept_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1; a = ta; b = tb_;
        cyc();
        in_valid = 1'b0; a = '0; b = '0;
        chk("model_exp", 64'(sb_q.size() > 0 ? sb_q[0] : '1), 64'(exp));
        n = 1;
        while (!out_valid && n < 50) begin
            chk("in_ready_low", 64'(in_ready), 64'd0);
            cyc(); n++;
        end
        chk("in_ready_low_done", 64'(in_ready), 64'd0);
        chk("latency", 64'(n), 64'd4);
        cyc();  // handshake; y compared by scoreboard
        chk("ready_after", 64'(in_ready), 64'd1);
        chk("idle_after", 64'(busy), 64'd0);
    endtask

    initial begin
        int acc;
        int cycles;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        @(negedge clk); cyc();
        // reset state
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_y", 64'(y), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        cyc();
        chk("post_rst_ready", 64'(in_ready), 64'd1);

        // directed
        run_op(16'h0003, 16'h0003, 31'h00000005);
        run_op(16'hFFFF, 16'hFFFF, 31'h55555555);
        run_op(16'h8000, 16'h8000, 31'h40000000);
        run_op(16'h0101, 16'h0101, 31'h00010001);
        run_op(16'h0100, 16'h00FF, 31'h0000FF00);
        run_op(16'h0000, 16'hBEEF, 31'h00000000);

        // backpressure
        out_ready = 1'b0;
        in_valid = 1'b1; a = 16'h1234; b = 16'h5678;
        cyc();
        in_valid = 1'b0;
        acc = 0;
        while (!out_valid && acc < 50) begin cyc(); acc++; end
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0]; a = 16'hFFFF; b = 16'hFFFF;
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_y", 64'(y), 64'(clmul(16'h1234, 16'h5678)));
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cyc();
        chk("bp_idle_ready", 64'(in_ready), 64'd1);
        chk("bp_out_cleared", 64'(out_valid), 64'd0);
        chk("bp_no_extra", 64'(sb_q.size()), 64'd0);

        // reset in MUL1
        in_valid = 1'b1; a = 16'hABCD; b = 16'h1357;
        cyc();            // -> MUL0
        in_valid = 1'b0;
        cyc();            // -> MUL1
        chk("mul1_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        cyc();
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_y", 64'(y), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        run_op(16'h0002, 16'h0004, 31'h00000008);

        // random regression with stalls on both sides
        acc = 0; cycles = 0;
        while ((acc < 3000 || sb_q.size() != 0) && cycles < 60000) begin
            in_valid  = (acc < 3000) && ($urandom_range(0, 3) != 0);
            a         = W'($urandom);
            b         = W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if (in_valid && in_ready) acc++;
            cyc();
            cycles++;
        end
        in_valid = 1'b0;
        chk("rand_accepted", 64'(acc), 64'd3000);
        chk("rand_drained", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
